// File: rtl/cok_cevrim_denetleyici.sv
// cok_cevrim_denetleyici: sequences the execute stage's multi-cycle units
// (pipelined multiplier, iterative divider, AI accelerator). It fires the start
// pulse, stalls upstream while the unit is busy and marks the single result cycle.
// Single-cycle units (birim 00) pass through untouched.
//
// Optional build macro CDD_ZAMAN_ASIMI_EN: adds a watchdog on the divider/AI wait.
// When the macro is undefined the wait is unbounded and hata_o is tied low.
module cok_cevrim_denetleyici #(
    parameter int unsigned CARP_GECIKME = 2,   // multiplier latency, 1..15
    parameter int unsigned ZAMAN_ASIMI  = 64   // watchdog limit (optional feature)
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       istek_gecerli_i,
    input  logic [1:0] istek_birim_i,
    input  logic       bosalt_i,
    input  logic       bol_bitti_i,
    input  logic       yzh_bitti_i,
    output logic       carp_basla_o,
    output logic       bol_basla_o,
    output logic       yzh_basla_o,
    output logic       iptal_o,
    output logic       durdur_o,
    output logic       sonuc_gecerli_o,
    output logic [1:0] sonuc_birim_o,
    output logic       hata_o
);

    typedef enum logic [2:0] {
        StBosta,
        StCarp,
        StBol,
        StYzh,
        StSonuc
    } durum_t;

    localparam logic [1:0] BirimTek  = 2'b00;
    localparam logic [1:0] BirimCarp = 2'b01;
    localparam logic [1:0] BirimBol  = 2'b10;
    localparam logic [1:0] BirimYzh  = 2'b11;

    // Counter value seen in the last CARP cycle before the result cycle.
    localparam logic [3:0] CarpSon = 4'(CARP_GECIKME - 1);

    durum_t     durum_q;
    logic [3:0] carp_sayac_q;
    logic [1:0] sonuc_birim_q;

    logic kabul;        // request accepted in BOSTA this cycle
    logic bekle;        // waiting on divider or AI
    logic bitti;        // matching done pulse for the unit being waited on
    logic zaman_doldu;  // watchdog expired this cycle (always 0 without the feature)

    // Request acceptance and completion detection.
    always_comb begin
        kabul = rst_ni && (durum_q == StBosta) && istek_gecerli_i
                && (istek_birim_i != BirimTek) && !bosalt_i;
        bekle = (durum_q == StBol) || (durum_q == StYzh);
        bitti = ((durum_q == StBol) && bol_bitti_i) || ((durum_q == StYzh) && yzh_bitti_i);
    end

`ifdef CDD_ZAMAN_ASIMI_EN
    localparam int unsigned ZsGen = $clog2(ZAMAN_ASIMI + 1);
    localparam logic [ZsGen-1:0] ZamanSon = ZsGen'(ZAMAN_ASIMI - 1);

    logic [ZsGen-1:0] bekle_sayac_q;

    // Watchdog counter: cleared when a divider/AI op starts, counts wait cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bekle_sayac_q <= '0;
        end else if (kabul) begin
            bekle_sayac_q <= '0;
        end else if (bekle && (bekle_sayac_q != ZamanSon)) begin
            bekle_sayac_q <= bekle_sayac_q + 1'b1;
        end
    end

    // Expiry on the ZAMAN_ASIMI-th wait cycle; a done pulse in that cycle wins.
    always_comb begin
        zaman_doldu = bekle && !bitti && (bekle_sayac_q == ZamanSon);
    end
`else
    // Without the watchdog the limit parameter has no effect.
    logic unused_zaman_asimi;
    assign unused_zaman_asimi = ^ZAMAN_ASIMI;

    // No watchdog: the wait never expires.
    always_comb begin
        zaman_doldu = 1'b0;
    end
`endif

    // Sequencing FSM: state, multiplier cycle counter and result-unit register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum_q       <= StBosta;
            carp_sayac_q  <= '0;
            sonuc_birim_q <= BirimTek;
        end else if (bosalt_i) begin
            // Flush beats done pulses and counter expiry.
            durum_q      <= StBosta;
            carp_sayac_q <= '0;
        end else begin
            unique case (durum_q)
                StBosta: begin
                    if (kabul) begin
                        unique case (istek_birim_i)
                            BirimCarp: begin
                                if (CARP_GECIKME <= 1) begin
                                    durum_q       <= StSonuc;
                                    sonuc_birim_q <= BirimCarp;
                                end else begin
                                    durum_q      <= StCarp;
                                    carp_sayac_q <= 4'd1;
                                end
                            end
                            BirimBol: durum_q <= StBol;
                            BirimYzh: durum_q <= StYzh;
                            default:  durum_q <= StBosta;
                        endcase
                    end
                end
                StCarp: begin
                    if (carp_sayac_q == CarpSon) begin
                        durum_q       <= StSonuc;
                        sonuc_birim_q <= BirimCarp;
                        carp_sayac_q  <= '0;
                    end else begin
                        carp_sayac_q <= carp_sayac_q + 4'd1;
                    end
                end
                StBol: begin
                    if (bitti) begin
                        durum_q       <= StSonuc;
                        sonuc_birim_q <= BirimBol;
                    end else if (zaman_doldu) begin
                        durum_q <= StBosta;
                    end
                end
                StYzh: begin
                    if (bitti) begin
                        durum_q       <= StSonuc;
                        sonuc_birim_q <= BirimYzh;
                    end else if (zaman_doldu) begin
                        durum_q <= StBosta;
                    end
                end
                StSonuc: begin
                    // The micro-op is still held at the input here; do not restart it.
                    durum_q <= StBosta;
                end
                default: durum_q <= StBosta;
            endcase
        end
    end

    // Outputs: start pulses and stall react in the accept cycle, so they are
    // combinational. Everything is gated by rst_ni so reset silences them at once.
    always_comb begin
        carp_basla_o    = kabul && (istek_birim_i == BirimCarp);
        bol_basla_o     = kabul && (istek_birim_i == BirimBol);
        yzh_basla_o     = kabul && (istek_birim_i == BirimYzh);
        iptal_o         = rst_ni && bekle && (bosalt_i || zaman_doldu);
        hata_o          = rst_ni && zaman_doldu && !bosalt_i;
        // The stall stays up through a watchdog abort; hata_o tells upstream why.
        durdur_o        = rst_ni && !bosalt_i
                          && (kabul || (durum_q == StCarp) || bekle);
        sonuc_gecerli_o = rst_ni && !bosalt_i && (durum_q == StSonuc);
        sonuc_birim_o   = sonuc_birim_q;
    end

endmodule

// File: tb/tb_cok_cevrim_denetleyici.sv
// Bench for cok_cevrim_denetleyici: a directed table, hand-written reset and
// watchdog sequences, then random stimulus against a timestamp-based model.
module tb_cok_cevrim_denetleyici;

    localparam int unsigned N = 2;
    localparam int unsigned Z = 8;

    logic       clk;
    logic       rst_n;
    logic       gecerli;
    logic [1:0] birim;
    logic       bosalt;
    logic       bol_bitti;
    logic       yzh_bitti;
    logic       carp_basla, bol_basla, yzh_basla, iptal, durdur, sonuc_gecerli, hata;
    logic [1:0] sonuc_birim;

    cok_cevrim_denetleyici #(
        .CARP_GECIKME(N),
        .ZAMAN_ASIMI (Z)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .istek_gecerli_i(gecerli),
        .istek_birim_i  (birim),
        .bosalt_i       (bosalt),
        .bol_bitti_i    (bol_bitti),
        .yzh_bitti_i    (yzh_bitti),
        .carp_basla_o   (carp_basla),
        .bol_basla_o    (bol_basla),
        .yzh_basla_o    (yzh_basla),
        .iptal_o        (iptal),
        .durdur_o       (durdur),
        .sonuc_gecerli_o(sonuc_gecerli),
        .sonuc_birim_o  (sonuc_birim),
        .hata_o         (hata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector order: carp, bol, yzh, iptal, durdur, sonuc, birim[1:0], hata
    logic [8:0] cikis;
    assign cikis = {carp_basla, bol_basla, yzh_basla, iptal, durdur, sonuc_gecerli,
                    sonuc_birim, hata};

    int gecen;
    int toplam;

    typedef struct {
        logic       g;
        logic [1:0] b;
        logic       fl;
        logic       bb;
        logic       yb;
        logic [8:0] bek;
    } satir_t;

    satir_t tablo[$];

    task automatic ekle(input logic g, input logic [1:0] b, input logic fl, input logic bb,
                        input logic yb, input logic [8:0] bek);
        satir_t s;
        s.g = g; s.b = b; s.fl = fl; s.bb = bb; s.yb = yb; s.bek = bek;
        tablo.push_back(s);
    endtask

    task automatic kontrol(input string ad, input logic [8:0] gercek, input logic [8:0] bek);
        toplam++;
        if (gercek === bek) gecen++;
        else $display("FAIL %s: got %b want %b (carp,bol,yzh,iptal,durdur,sonuc,birim,hata)",
                      ad, gercek, bek);
    endtask

    // One cycle: drive at posedge+1, check at negedge, return to posedge+1.
    task automatic adim(input string ad, input logic g, input logic [1:0] b, input logic fl,
                        input logic bb, input logic yb, input logic [8:0] bek);
        gecerli = g; birim = b; bosalt = fl; bol_bitti = bb; yzh_bitti = yb;
        @(negedge clk);
        kontrol(ad, cikis, bek);
        @(posedge clk);
        #1;
    endtask

    task automatic sifirla();
        gecerli = 1'b0; birim = 2'b00; bosalt = 1'b0; bol_bitti = 1'b0; yzh_bitti = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Reference model: tracks the op in flight by its start time and the cycle
    // at which its result is due, not by controller states.
    bit         m_mesgul;
    logic [1:0] m_birim;
    logic [1:0] m_son;
    int         m_dongu;
    int         m_baslangic;
    int         m_sonuc_dongu;

    function automatic logic [8:0] model_adim(input logic g, input logic [1:0] b,
                                              input logic fl, input logic bb, input logic yb);
        logic c, bo, y, ip, d, s, h;
        c = 0; bo = 0; y = 0; ip = 0; d = 0; s = 0; h = 0;
        if (m_mesgul && m_sonuc_dongu == m_dongu) begin
            m_son    = m_birim;
            s        = !fl;
            m_mesgul = 0;
        end else if (m_mesgul) begin
            if (fl) begin
                ip       = (m_birim != 2'b01);
                m_mesgul = 0;
            end else begin
                d = 1;
                if ((m_birim == 2'b10 && bb) || (m_birim == 2'b11 && yb))
                    m_sonuc_dongu = m_dongu + 1;
`ifdef CDD_ZAMAN_ASIMI_EN
                else if (m_birim != 2'b01 && (m_dongu - m_baslangic) == int'(Z)) begin
                    h = 1; ip = 1; m_mesgul = 0;
                end
`endif
            end
        end else if (g && b != 2'b00 && !fl) begin
            c = (b == 2'b01); bo = (b == 2'b10); y = (b == 2'b11);
            d = 1;
            m_mesgul      = 1;
            m_birim       = b;
            m_baslangic   = m_dongu;
            m_sonuc_dongu = (b == 2'b01) ? m_dongu + int'(N) : -1;
        end
        m_dongu++;
        return {c, bo, y, ip, d, s, m_son, h};
    endfunction

    initial begin
        gecen = 0; toplam = 0;
        rst_n = 1'b0;
        // Request present during reset must not leak through.
        gecerli = 1'b1; birim = 2'b01; bosalt = 1'b0; bol_bitti = 1'b1; yzh_bitti = 1'b0;
        #12;
        kontrol("reset_state", cikis, 9'b0);
        gecerli = 1'b0; birim = 2'b00; bol_bitti = 1'b0;
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table                          c_b_y_i_d_s_uu_h
        ekle(1, 2'b00, 0, 0, 0, 9'b0_0_0_0_0_0_00_0);  // single-cycle unit
        ekle(1, 2'b01, 1, 0, 0, 9'b0_0_0_0_0_0_00_0);  // flush blocks start
        ekle(0, 2'b00, 0, 1, 1, 9'b0_0_0_0_0_0_00_0);  // stray done pulses
        ekle(1, 2'b01, 0, 0, 0, 9'b1_0_0_0_1_0_00_0);  // mul T0
        ekle(1, 2'b01, 0, 0, 0, 9'b0_0_0_0_1_0_00_0);
        ekle(1, 2'b01, 0, 0, 0, 9'b0_0_0_0_0_1_01_0);  // mul result T2, held op ignored
        ekle(0, 2'b00, 0, 0, 0, 9'b0_0_0_0_0_0_01_0);
        ekle(1, 2'b10, 0, 1, 0, 9'b0_1_0_0_1_0_01_0);  // div T0, done at T0 ignored
        for (int i = 0; i < 4; i++) ekle(1, 2'b10, 0, 0, 0, 9'b0_0_0_0_1_0_01_0);
        ekle(1, 2'b10, 0, 1, 0, 9'b0_0_0_0_1_0_01_0);  // done at T5
        ekle(1, 2'b10, 0, 0, 0, 9'b0_0_0_0_0_1_10_0);  // result T6
        ekle(0, 2'b00, 0, 0, 0, 9'b0_0_0_0_0_0_10_0);
        ekle(1, 2'b10, 0, 0, 0, 9'b0_1_0_0_1_0_10_0);  // cross-unit: div T0
        ekle(1, 2'b10, 0, 0, 0, 9'b0_0_0_0_1_0_10_0);
        ekle(1, 2'b10, 0, 0, 0, 9'b0_0_0_0_1_0_10_0);
        ekle(1, 2'b10, 0, 0, 1, 9'b0_0_0_0_1_0_10_0);  // AI done at T3 ignored
        for (int i = 0; i < 3; i++) ekle(1, 2'b10, 0, 0, 0, 9'b0_0_0_0_1_0_10_0);
        ekle(1, 2'b10, 0, 1, 0, 9'b0_0_0_0_1_0_10_0);  // div done T7
        ekle(0, 2'b00, 0, 0, 0, 9'b0_0_0_0_0_1_10_0);  // result T8
        ekle(0, 2'b00, 0, 0, 0, 9'b0_0_0_0_0_0_10_0);
        ekle(1, 2'b11, 0, 0, 0, 9'b0_0_1_0_1_0_10_0);  // AI T0
        for (int i = 0; i < 3; i++) ekle(1, 2'b11, 0, 0, 0, 9'b0_0_0_0_1_0_10_0);
        ekle(1, 2'b11, 1, 0, 0, 9'b0_0_0_1_0_0_10_0);  // flush T4 -> abort
        ekle(0, 2'b00, 0, 0, 0, 9'b0_0_0_0_0_0_10_0);
        ekle(0, 2'b00, 0, 0, 1, 9'b0_0_0_0_0_0_10_0);  // late AI done: no result
        ekle(0, 2'b00, 0, 0, 0, 9'b0_0_0_0_0_0_10_0);
        ekle(1, 2'b01, 0, 0, 0, 9'b1_0_0_0_1_0_10_0);  // back-to-back mul
        ekle(1, 2'b01, 0, 0, 0, 9'b0_0_0_0_1_0_10_0);
        ekle(1, 2'b01, 0, 0, 0, 9'b0_0_0_0_0_1_01_0);
        ekle(1, 2'b01, 0, 0, 0, 9'b1_0_0_0_1_0_01_0);  // second start T3
        ekle(1, 2'b01, 0, 0, 0, 9'b0_0_0_0_1_0_01_0);
        ekle(1, 2'b01, 0, 0, 0, 9'b0_0_0_0_0_1_01_0);  // second result T5
        ekle(0, 2'b00, 0, 0, 0, 9'b0_0_0_0_0_0_01_0);
        ekle(1, 2'b01, 0, 0, 0, 9'b1_0_0_0_1_0_01_0);  // flush in CARP
        ekle(1, 2'b01, 1, 0, 0, 9'b0_0_0_0_0_0_01_0);
        ekle(0, 2'b00, 0, 0, 0, 9'b0_0_0_0_0_0_01_0);
        ekle(1, 2'b11, 0, 0, 0, 9'b0_0_1_0_1_0_01_0);  // AI, flush in result cycle
        ekle(1, 2'b11, 0, 0, 1, 9'b0_0_0_0_1_0_01_0);
        ekle(1, 2'b11, 1, 0, 0, 9'b0_0_0_0_0_0_11_0);
        ekle(0, 2'b00, 0, 0, 0, 9'b0_0_0_0_0_0_11_0);
        ekle(1, 2'b10, 0, 0, 0, 9'b0_1_0_0_1_0_11_0);  // flush beats done in BOL
        ekle(1, 2'b10, 1, 1, 0, 9'b0_0_0_1_0_0_11_0);
        ekle(0, 2'b00, 0, 0, 0, 9'b0_0_0_0_0_0_11_0);

        foreach (tablo[i]) begin
            adim($sformatf("tablo[%0d]", i), tablo[i].g, tablo[i].b, tablo[i].fl,
                 tablo[i].bb, tablo[i].yb, tablo[i].bek);
        end

        // Asynchronous reset in the middle of a divider wait.
        adim("rst_bol_t0", 1, 2'b10, 0, 0, 0, 9'b0_1_0_0_1_0_11_0);
        adim("rst_bol_t1", 1, 2'b10, 0, 0, 0, 9'b0_0_0_0_1_0_11_0);
        #2;
        rst_n = 1'b0;
        #1;
        kontrol("rst_async_outputs", cikis, 9'b0);
        gecerli = 1'b0; birim = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        adim("rst_after_idle", 0, 2'b00, 0, 0, 1, 9'b0);

`ifdef CDD_ZAMAN_ASIMI_EN
        // Watchdog expiry, then done arriving exactly on the limit cycle.
        adim("wd_start", 1, 2'b10, 0, 0, 0, 9'b0_1_0_0_1_0_00_0);
        for (int i = 1; i < int'(Z); i++)
            adim("wd_wait", 0, 2'b00, 0, 0, 0, 9'b0_0_0_0_1_0_00_0);
        adim("wd_expire", 0, 2'b00, 0, 0, 0, 9'b0_0_0_1_1_0_00_1);
        adim("wd_idle", 0, 2'b00, 0, 0, 0, 9'b0);
        adim("wd2_start", 1, 2'b10, 0, 0, 0, 9'b0_1_0_0_1_0_00_0);
        for (int i = 1; i < int'(Z); i++)
            adim("wd2_wait", 0, 2'b00, 0, 0, 0, 9'b0_0_0_0_1_0_00_0);
        adim("wd2_done_wins", 0, 2'b00, 0, 1, 0, 9'b0_0_0_0_1_0_00_0);
        adim("wd2_result", 0, 2'b00, 0, 0, 0, 9'b0_0_0_0_0_1_10_0);
`endif

        // Random stimulus against the model.
        sifirla();
        m_mesgul = 0; m_birim = 2'b00; m_son = 2'b00; m_dongu = 0;
        m_baslangic = 0; m_sonuc_dongu = -1;
        for (int i = 0; i < 600; i++) begin
            logic       g, fl, bb, yb;
            logic [1:0] b;
            logic [8:0] bek;
            g  = ($urandom % 4) != 0;
            b  = 2'($urandom % 4);
            fl = ($urandom % 16) == 0;
            bb = ($urandom % 5) == 0;
            yb = ($urandom % 5) == 0;
            bek = model_adim(g, b, fl, bb, yb);
            adim($sformatf("rastgele[%0d]", i), g, b, fl, bb, yb, bek);
        end

        $display("%0d/%0d checks passed", gecen, toplam);
        $finish;
    end

endmodule

// File: doc/cok_cevrim_denetleyici.md
Name: cok_cevrim_denetleyici

Overview:
Sequencing controller for the multi-cycle resources of the execute stage: the pipelined multiplier, the iterative divider and the AI accelerator.
It takes the unit-select decoded from the incoming micro-op and pulses the matching start line. It then holds the pipeline with a stall while the unit is busy and flags the one cycle in which the result is valid for writeback.
Single-cycle units (ALU, crypto, branch) pass through with no stall.

Parameters:
CARP_GECIKME, 2, multiplier pipeline depth in cycles (legal range 1..15)
ZAMAN_ASIMI, 64, watchdog limit in cycles for divider/AI wait (used only with CDD_ZAMAN_ASIMI_EN)

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset, asynchronous, active-low
istek_gecerli_i  input  1  micro-op at execute input is valid
istek_birim_i  input  2  unit select: 00 single-cycle, 01 multiplier, 10 divider, 11 AI accelerator
bosalt_i  input  1  pipeline flush
bol_bitti_i  input  1  divider done pulse
yzh_bitti_i  input  1  AI accelerator done pulse
carp_basla_o  output  1  multiplier start pulse
bol_basla_o  output  1  divider start pulse
yzh_basla_o  output  1  AI start pulse
iptal_o  output  1  abort pulse to divider/AI
durdur_o  output  1  stall upstream pipeline
sonuc_gecerli_o  output  1  result of multi-cycle op valid this cycle
sonuc_birim_o  output  2  unit that produced the current/last result
hata_o  output  1  watchdog timeout pulse

Behaviour:
- Reset:
  - state BOSTA, counters 0.
  - All outputs 0; sonuc_birim_o = 00.
- States: BOSTA, CARP, BOL, YZH, SONUC; state register is asynchronous-reset.
- BOSTA, with istek_gecerli_i=1, birim!=00 and bosalt_i=0, in the same cycle T0:
  - Corresponding *_basla_o = 1 (combinational, one cycle only).
  - durdur_o = 1 (combinational).
  - Next state is CARP, BOL or YZH.
- BOSTA otherwise: durdur_o = 0 and no start pulse.
- CARP:
  - Cycle counter, width 4.
  - SONUC is entered so that sonuc_gecerli_o = 1 exactly at cycle T0+CARP_GECIKME.
  - CARP_GECIKME=1 goes BOSTA->SONUC directly.
  - durdur_o = 1 in every cycle before SONUC.
- BOL / YZH:
  - durdur_o = 1.
  - Wait for the matching *_bitti_i = 1; the other unit's bitti is ignored.
  - bitti sampled high at cycle Tn -> SONUC at Tn+1.
  - bitti in the T0 start cycle is ignored; it is only sampled in the BOL/YZH states.
- SONUC:
  - sonuc_gecerli_o = 1 and durdur_o = 0 for exactly one cycle.
  - sonuc_birim_o is registered on SONUC entry and holds until the next SONUC.
  - istek_* inputs are ignored in this cycle: the held micro-op is still present and must not restart.
  - Next state BOSTA.
  - Back-to-back multi-cycle ops therefore have a minimum 1-cycle gap (the SONUC cycle) between start pulses.
- bosalt_i = 1 in any state:
  - Next state BOSTA.
  - No sonuc_gecerli_o and no start pulse in that cycle.
  - durdur_o = 0 in that cycle.
  - If the current state is BOL or YZH, iptal_o = 1 for that cycle.
  - Flush takes priority over bitti and over counter expiry in the same cycle.
- bitti pulses arriving in BOSTA/CARP/SONUC are ignored.
- Reset asserted mid-operation: outputs drop to 0 immediately (asynchronous). No iptal_o is generated; the units are reset by the same rst_ni.
- istek_birim_i is sampled only in BOSTA; changes while busy are ignored.

Optional Feature:
CDD_ZAMAN_ASIMI_EN:
- Defined:
  - A counter runs in BOL/YZH, cleared on entry.
  - If no bitti arrives by the ZAMAN_ASIMI-th cycle in state: hata_o = 1 and iptal_o = 1 for one cycle, next state BOSTA, no sonuc_gecerli_o.
  - bitti in that same cycle wins (normal completion, no hata_o).
- Undefined: no counter logic, hata_o tied 0, wait is unbounded.

Test Plan:
- Multiplier, CARP_GECIKME=2: valid with birim=01 at T0 -> carp_basla_o=1 at T0; durdur_o=1 at T0,T1; sonuc_gecerli_o=1 and durdur_o=0 at T2; sonuc_birim_o=01.
- Divider: birim=10 at T0, bol_bitti_i pulsed at T5 -> durdur_o=1 T0..T5; sonuc_gecerli_o=1 at T6; bol_basla_o pulsed only at T0.
- Cross-unit ignore: in BOL, yzh_bitti_i pulse at T3 then bol_bitti_i at T7 -> no effect at T3; SONUC at T8.
- Flush: in YZH at T4 with bosalt_i=1 -> iptal_o=1 and durdur_o=0 at T4; BOSTA at T5; a later yzh_bitti_i produces no sonuc_gecerli_o.
- Back-to-back: two multiplies presented consecutively (second held during stall) -> start pulses at T0 and T3; two sonuc_gecerli_o pulses at T2 and T5.
- Watchdog (CDD_ZAMAN_ASIMI_EN, ZAMAN_ASIMI=8): divider start at T0, no bitti -> hata_o=1 and iptal_o=1 in the 8th BOL cycle; BOSTA next; asynchronous rst_ni low mid-wait zeroes all outputs immediately.
